// File: rtl/mod_pow2_mul_ctrl.sv
// Sequenced modular multiply-by-power-of-two: oData = iData * 2^iShift mod iQ, one doubling per cycle.
// Optional build macro MOD_POW2_EARLY_EXIT_EN: leave RUN as soon as the accumulator is zero.
module mod_pow2_mul_ctrl #(
   parameter int BITWIDTH = 8,
   parameter int SHIFTW   = 4
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iClr,
   input  logic                iValid,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iData,
   input  logic [BITWIDTH-1:0] iQ,
   input  logic [SHIFTW-1:0]   iShift,
   output logic                oValid,
   input  logic                iReady,
   output logic [BITWIDTH-1:0] oData,
   output logic                oBusy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state, state_nxt;
   logic [BITWIDTH-1:0] acc, q;
   logic [SHIFTW-1:0]   cnt;
   logic [BITWIDTH:0]   dbl, dbl_red;

   // Compare and subtract at BITWIDTH+1 bits so the shifted-out MSB takes part.
   always_comb begin
      dbl     = {acc, 1'b0};
      dbl_red = (dbl < {1'b0, q}) ? dbl : dbl - {1'b0, q};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (iValid) state_nxt = (iShift == '0) ? DONE : RUN;
         RUN: begin
`ifdef MOD_POW2_EARLY_EXIT_EN
            if (acc == '0) state_nxt = DONE;
            else if (cnt == SHIFTW'(1)) state_nxt = DONE;
`else
            if (cnt == SHIFTW'(1)) state_nxt = DONE;
`endif
         end
         DONE: if (iReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst || iClr) begin
         state <= IDLE;
         acc   <= '0;
         q     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (iValid) begin
               acc <= iData;
               q   <= iQ;
               cnt <= iShift;
            end
            RUN: begin
               acc <= dbl_red[BITWIDTH-1:0];
               cnt <= cnt - SHIFTW'(1);
            end
            default: ;
         endcase
      end
   end

   assign oReady = (state == IDLE);
   assign oValid = (state == DONE);
   assign oBusy  = (state != IDLE);
   assign oData  = acc;

endmodule
